counter_timer: RTL and testbench
================================

COUNTER_TIMER -- requirements
Module: counter_timer

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed 32-bit.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-004 Addr  input  2  word select from bridge (PrAddr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 WE  input  1  bridge write strobe; full-word write when high, sampled at rising edge.
REQ-006 DIn  input  32  write data from bridge (CPU PrDOut).
REQ-007 DOut  output  32  read data to bridge (CPU PrDIn), combinational from Addr.
REQ-008 IRQ  output  1  interrupt request, drives one HWInt line.

Function
REQ-009 CTRL register: bit0 EN (count enable), bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1=enabled); bits[31:4] SHALL read 0.
REQ-010 PRESET SHALL be a 32-bit read/write register; COUNT a 32-bit read-only register.
REQ-011 DOut SHALL return CTRL/PRESET/COUNT for Addr 0/1/2, and 32'h0 for Addr 3, with no cycle delay.
REQ-012 WE with Addr=0 SHALL write CTRL[3:0] from DIn[3:0] and clear the IRQ flag; Addr=1 SHALL write PRESET and clear the IRQ flag; Addr=2 or 3 writes SHALL be ignored.
REQ-013 FSM states: IDLE, LOAD, CNT, INT; reset state IDLE.
REQ-014 IDLE: EN=1 -> LOAD next edge; else stay.
REQ-015 LOAD: COUNT <= PRESET; -> CNT.
REQ-016 CNT: EN=0 -> IDLE with COUNT held; else COUNT>1 -> COUNT-1, stay; COUNT<=1 -> COUNT <= 0, IRQ flag <= 1, -> INT.
REQ-017 INT, MODE=one-shot: CTRL.EN <= 0, -> IDLE; IRQ flag held (sticky) until cleared per REQ-012.
REQ-018 INT, MODE=auto-reload: -> LOAD; IRQ flag cleared on this edge (flag is a one-cycle pulse).
REQ-019 IRQ SHALL equal IRQ flag AND CTRL.IM (registered flag, combinational mask).
REQ-020 Latency: CTRL write with EN=1 at edge E0, PRESET=N>=1 -> LOAD at E1, COUNT=N after E2, COUNT=0 and IRQ flag=1 after E(N+2).
REQ-021 PRESET=0 SHALL behave as PRESET=1 timing-wise (COUNT=0 in CNT -> INT next edge); no underflow wrap.
REQ-022 PRESET written during CNT SHALL not alter COUNT; new value takes effect at next LOAD.
REQ-023 CPU write to CTRL on the same edge as the INT one-shot EN clear: CPU write SHALL win for all CTRL bits; IRQ flag cleared.
REQ-024 CTRL write EN=0 during CNT: state -> IDLE on the following edge; COUNT frozen; re-enable restarts via LOAD from PRESET.

Reset
REQ-025 rst=1 at a rising edge SHALL set CTRL=0, PRESET=0, COUNT=0, IRQ flag=0, state=IDLE, regardless of WE or state.
REQ-026 After reset IRQ=0 and DOut=0 for every Addr; rst asserted mid-count SHALL abort counting with no IRQ.

Verification
REQ-027 Reset then read Addr 0..3 -> DOut=0 each; IRQ=0.
REQ-028 Write PRESET=5, CTRL=4'b1001 (one-shot, IM=1, EN=1) -> COUNT reads 5,4,3,2,1,0 on successive cycles after LOAD; IRQ=1 at edge E7; CTRL reads 4'b1000; IRQ stays 1 until CTRL write.
REQ-029 PRESET=3, CTRL=4'b1011 (auto-reload) -> IRQ one-cycle pulse every 5 cycles; COUNT sequence 3,2,1,0,(LOAD)3...
REQ-030 PRESET=10, CTRL=4'b0001 (IM=0) -> counts to 0, IRQ stays 0; then write CTRL=4'b1000 -> IRQ stays 0 (flag cleared by write).
REQ-031 Mid-count (COUNT=6): write CTRL EN=0 -> COUNT holds 6 across 4 cycles; write PRESET=2 during hold, re-enable -> COUNT reloads 2, IRQ after 4 edges.
REQ-032 Assert rst at COUNT=3 -> next edge all registers 0, IRQ=0, no further counting; write to Addr 2 with DIn=32'hFFFF -> COUNT unchanged.

Source files
------------

// File: rtl/counter_timer_if.sv
// Bridge-side register bus of the counter/timer peripheral.
// Word select, write strobe and data in; read data and IRQ out.
interface counter_timer_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  modport master (
    output Addr, WE, DIn,
    input  DOut, IRQ
  );

  modport slave (
    input  Addr, WE, DIn,
    output DOut, IRQ
  );
endinterface

// File: rtl/counter_timer.sv
// 32-bit down-counter timer with one-shot and auto-reload modes.
// CTRL/PRESET/COUNT registers behind a two-bit word-select bus.
module counter_timer (
  input  logic             clk,
  input  logic             rst,
  counter_timer_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        en;
  logic        im;
  logic        reload;
  logic        wr_ctrl;
  logic        wr_preset;

  assign en        = ctrl[0];
  assign im        = ctrl[3];
  assign reload    = (ctrl[2:1] == 2'b01);
  assign wr_ctrl   = bus.WE && (bus.Addr == 2'd0);
  assign wr_preset = bus.WE && (bus.Addr == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (en) state <= S_LOAD;
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= 32'd0;
            irq_flag <= 1'b1;
            state    <= S_INT;
          end
        end
        S_INT: begin
          if (reload) begin
            irq_flag <= 1'b0;
            state    <= S_LOAD;
          end else begin
            ctrl[0] <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // CPU writes come last so they win over the FSM's EN clear
      if (wr_ctrl) begin
        ctrl     <= bus.DIn[3:0];
        irq_flag <= 1'b0;
      end
      if (wr_preset) begin
        preset   <= bus.DIn;
        irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.DOut = 32'd0;
    unique case (bus.Addr)
      2'd0:    bus.DOut = {28'd0, ctrl};
      2'd1:    bus.DOut = preset;
      2'd2:    bus.DOut = count;
      default: bus.DOut = 32'd0;
    endcase
  end

  assign bus.IRQ = irq_flag & im;
endmodule

// File: tb/tb_counter_timer.sv
// Directed bench for counter_timer: stimulus pushes expected reads,
// an independent monitor pops and compares against DOut/IRQ.
module tb_counter_timer;
  logic clk;
  logic rst;

  counter_timer_if bus ();

  counter_timer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [1:0]  a;
    logic [31:0] d;
    logic        q;
  } exp_t;

  exp_t sb[$];
  event pushed;
  int   n_cmp;
  int   n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(pushed);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.DOut !== e.d || bus.IRQ !== e.q) begin
          n_bad++;
          $display("FAIL %s: addr=%0d dout=%h irq=%b, want dout=%h irq=%b",
                   e.tag, e.a, bus.DOut, bus.IRQ, e.d, e.q);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.DIn  = d;
    bus.WE   = 1'b1;
    tick(1);
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] d,
                    input logic q, input string tag);
    exp_t e;
    bus.Addr = a;
    e.tag = tag;
    e.a   = a;
    e.d   = d;
    e.q   = q;
    sb.push_back(e);
    ->pushed;
    #2;
  endtask

  initial begin
    logic [31:0] seq3 [5];
    n_cmp = 0;
    n_bad = 0;
    bus.Addr = 2'd0;
    bus.WE   = 1'b0;
    bus.DIn  = 32'd0;
    rst = 1'b1;

    // reset with a write pending; reset must win
    @(negedge clk);
    bus.WE = 1'b1; bus.Addr = 2'd1; bus.DIn = 32'hDEAD_BEEF;
    tick(2);
    bus.WE = 1'b0;
    rst = 1'b0;
    rd(2'd0, 32'd0, 1'b0, "rst_ctrl");
    rd(2'd1, 32'd0, 1'b0, "rst_preset");
    rd(2'd2, 32'd0, 1'b0, "rst_count");
    tick(1);
    rd(2'd3, 32'd0, 1'b0, "rst_rsvd");

    // one-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(2);
    rd(2'd2, 32'd5, 1'b0, "os_count5");
    for (int k = 4; k >= 0; k--) begin
      tick(1);
      rd(2'd2, 32'(k), (k == 0), $sformatf("os_count%0d", k));
    end
    tick(1);
    rd(2'd0, 32'h8, 1'b1, "os_en_cleared");
    tick(3);
    rd(2'd0, 32'h8, 1'b1, "os_irq_sticky");
    rd(2'd2, 32'd0, 1'b1, "os_count_held0");
    wr(2'd0, 32'h8);
    rd(2'd0, 32'h8, 1'b0, "os_irq_cleared");

    // auto-reload, PRESET=3
    seq3[0] = 32'd3; seq3[1] = 32'd2; seq3[2] = 32'd1;
    seq3[3] = 32'd0; seq3[4] = 32'd0;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    tick(2);
    for (int i = 0; i < 11; i++) begin
      rd(2'd2, seq3[i % 5], ((i % 5) == 3), $sformatf("ar_step%0d", i));
      tick(1);
    end
    wr(2'd0, 32'h0);
    tick(5);

    // IM=0: flag sets but IRQ masked; CTRL write clears flag
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    tick(2);
    for (int k = 10; k >= 0; k--) begin
      rd(2'd2, 32'(k), 1'b0, $sformatf("mask_count%0d", k));
      if (k > 0) tick(1);
    end
    tick(1);
    wr(2'd0, 32'h8);
    rd(2'd0, 32'h8, 1'b0, "mask_unmask_clr");

    // pause mid-count at 6, change PRESET, resume
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    tick(5);
    rd(2'd2, 32'd7, 1'b0, "pause_pre7");
    wr(2'd0, 32'h8);
    for (int i = 0; i < 4; i++) begin
      rd(2'd2, 32'd6, 1'b0, $sformatf("pause_hold%0d", i));
      tick(1);
    end
    wr(2'd1, 32'd2);
    rd(2'd2, 32'd6, 1'b0, "pause_hold_preset");
    wr(2'd0, 32'h9);
    tick(2);
    rd(2'd2, 32'd2, 1'b0, "resume_count2");
    tick(1);
    rd(2'd2, 32'd1, 1'b0, "resume_count1");
    tick(1);
    rd(2'd2, 32'd0, 1'b1, "resume_irq");
    wr(2'd0, 32'h8);

    // PRESET=0 behaves as PRESET=1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick(2);
    rd(2'd2, 32'd0, 1'b0, "p0_load");
    tick(1);
    rd(2'd2, 32'd0, 1'b1, "p0_irq");
    tick(1);
    rd(2'd0, 32'h8, 1'b1, "p0_oneshot_done");
    wr(2'd0, 32'h8);

    // CPU CTRL write collides with one-shot EN clear
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick(2);
    rd(2'd2, 32'd1, 1'b0, "race_count1");
    tick(1);
    rd(2'd2, 32'd0, 1'b1, "race_irq");
    wr(2'd0, 32'hB);
    rd(2'd0, 32'hB, 1'b0, "race_cpu_wins");
    wr(2'd0, 32'h0);
    tick(5);

    // PRESET write during count, then reset mid-count
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    tick(2);
    rd(2'd2, 32'd10, 1'b0, "rc_count10");
    wr(2'd1, 32'd77);
    tick(6);
    rd(2'd2, 32'd3, 1'b0, "rc_count3");
    rd(2'd1, 32'd77, 1'b0, "rc_preset77");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rd(2'd0, 32'd0, 1'b0, "rc_ctrl0");
    rd(2'd1, 32'd0, 1'b0, "rc_preset0");
    rd(2'd2, 32'd0, 1'b0, "rc_count0");
    tick(1);
    rd(2'd3, 32'd0, 1'b0, "rc_rsvd0");
    tick(3);
    rd(2'd2, 32'd0, 1'b0, "rc_no_count");
    wr(2'd2, 32'hFFFF);
    rd(2'd2, 32'd0, 1'b0, "rc_count_ro");
    wr(2'd3, 32'hFFFF);
    rd(2'd3, 32'd0, 1'b0, "rc_rsvd_ro");
    rd(2'd0, 32'd0, 1'b0, "rc_ctrl_untouched");

    #20;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
